// File: rtl/morse_shift_in.sv
// Morse receiver: samples a keyed line once per unit strobe, measures mark/space runs
// and hands DOT/DASH/gap/ERR symbols to a one-deep valid/ready output register.
// Ports: clk, rst_n (async, active-low), S_DATA (1=mark), sample (unit strobe),
//        sym/sym_valid/sym_ready (symbol output handshake), overflow (sticky), busy.
module morse_shift_in #(
  parameter int CNT_W      = 4,
  parameter int DASH_MIN   = 3,
  parameter int LETTER_MIN = 3,
  parameter int WORD_MIN   = 7,
  parameter int ERR_MARK   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       S_DATA,
  input  logic       sample,
  output logic [2:0] sym,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic       overflow,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    SPACE
  } state_t;

  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_MAX  = '1;
  localparam logic [CNT_W-1:0] C_DASH = CNT_W'(DASH_MIN);
  localparam logic [CNT_W-1:0] C_LET  = CNT_W'(LETTER_MIN);
  localparam logic [CNT_W-1:0] C_WORD = CNT_W'(WORD_MIN);
  localparam logic [CNT_W-1:0] C_ERR  = CNT_W'(ERR_MARK);

  localparam logic [2:0] SYM_DOT  = 3'd1;
  localparam logic [2:0] SYM_DASH = 3'd7;
  localparam logic [2:0] SYM_LG   = 3'd2;
  localparam logic [2:0] SYM_WG   = 3'd4;
  localparam logic [2:0] SYM_ERR  = 3'd6;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             emit;
  logic [2:0]       emit_sym;

  assign cnt_inc = (cnt == C_MAX) ? cnt : cnt + C_ONE;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    emit     = 1'b0;
    emit_sym = 3'd0;
    if (sample) begin
      unique case (state)
        IDLE: begin
          // leading silence is not counted
          if (S_DATA) begin
            state_n = MARK;
            cnt_n   = C_ONE;
          end
        end
        MARK: begin
          if (S_DATA) begin
            cnt_n = cnt_inc;
            // cnt != C_ERR keeps ERR single-shot if the counter pins there
            if (cnt_inc == C_ERR && cnt != C_ERR) begin
              emit     = 1'b1;
              emit_sym = SYM_ERR;
            end
          end else begin
            // an over-long mark already reported ERR; release is silent
            if (cnt < C_ERR) begin
              emit     = 1'b1;
              emit_sym = (cnt < C_DASH) ? SYM_DOT : SYM_DASH;
            end
            state_n = SPACE;
            cnt_n   = C_ONE;
          end
        end
        SPACE: begin
          if (!S_DATA) begin
            cnt_n = cnt_inc;
            if (cnt_inc == C_WORD && cnt != C_WORD) begin
              emit     = 1'b1;
              emit_sym = SYM_WG;
              state_n  = IDLE;
              cnt_n    = '0;
            end
          end else begin
            if (cnt >= C_LET && cnt < C_WORD) begin
              emit     = 1'b1;
              emit_sym = SYM_LG;
            end
            state_n = MARK;
            cnt_n   = C_ONE;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym       <= 3'd0;
      sym_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (emit) begin
      if (!sym_valid || sym_ready) begin
        sym       <= emit_sym;
        sym_valid <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (sym_valid && sym_ready) begin
      sym_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_morse_shift_in.sv
// Directed bench for morse_shift_in: idle line, letter, word gap, long mark,
// backpressure/overflow and asynchronous reset mid-run.
module tb_morse_shift_in;

  logic       clk;
  logic       rst_n;
  logic       S_DATA;
  logic       sample;
  logic [2:0] sym;
  logic       sym_valid;
  logic       sym_ready;
  logic       overflow;
  logic       busy;

  int n_cmp;
  int n_bad;

  morse_shift_in dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .S_DATA    (S_DATA),
    .sample    (sample),
    .sym       (sym),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic strobe(input logic d);
    S_DATA = d;
    sample = 1'b1;
    @(posedge clk);
    #1;
    sample = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sample = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [9:0] let_d;
  logic [9:0] let_v;
  logic [2:0] let_s [10];

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    S_DATA    = 1'b0;
    sample    = 1'b0;
    sym_ready = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sym",   8'(sym), 8'd0);
    chk("rst_valid", 8'(sym_valid), 8'd0);
    chk("rst_ovf",   8'(overflow), 8'd0);
    chk("rst_busy",  8'(busy), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();

    // idle line
    for (int i = 0; i < 20; i++) begin
      strobe(1'b0);
      chk("idle_valid", 8'(sym_valid), 8'd0);
      chk("idle_busy",  8'(busy), 8'd0);
    end
    chk("idle_ovf", 8'(overflow), 8'd0);

    // letter sequence, strobe 1 first (bit 0)
    sym_ready = 1'b1;
    let_d = 10'b0100011101;
    let_v = 10'b1100100010;
    let_s[0] = 3'd0; let_s[1] = 3'd1; let_s[2] = 3'd0;
    let_s[3] = 3'd0; let_s[4] = 3'd0; let_s[5] = 3'd7;
    let_s[6] = 3'd0; let_s[7] = 3'd0; let_s[8] = 3'd2;
    let_s[9] = 3'd1;
    for (int i = 0; i < 10; i++) begin
      strobe(let_d[i]);
      chk($sformatf("let_valid%0d", i + 1), 8'(sym_valid), 8'(let_v[i]));
      if (let_v[i])
        chk($sformatf("let_sym%0d", i + 1), 8'(sym), 8'(let_s[i]));
      chk($sformatf("let_busy%0d", i + 1), 8'(busy), 8'd1);
    end
    chk("let_ovf", 8'(overflow), 8'd0);

    // word gap
    do_reset();
    strobe(1'b1);
    chk("wg_v1", 8'(sym_valid), 8'd0);
    strobe(1'b0);
    chk("wg_v2", 8'(sym_valid), 8'd1);
    chk("wg_dot", 8'(sym), 8'd1);
    for (int i = 3; i <= 7; i++) begin
      strobe(1'b0);
      chk($sformatf("wg_v%0d", i), 8'(sym_valid), 8'd0);
      chk($sformatf("wg_busy%0d", i), 8'(busy), 8'd1);
    end
    strobe(1'b0);
    chk("wg_v8",   8'(sym_valid), 8'd1);
    chk("wg_sym",  8'(sym), 8'd4);
    chk("wg_busy", 8'(busy), 8'd0);
    for (int i = 0; i < 5; i++) begin
      strobe(1'b0);
      chk("wg_after_v", 8'(sym_valid), 8'd0);
      chk("wg_after_b", 8'(busy), 8'd0);
    end

    // long mark
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      strobe(1'b1);
      chk($sformatf("lm_v%0d", i), 8'(sym_valid), 8'd0);
    end
    strobe(1'b1);
    chk("lm_v8",   8'(sym_valid), 8'd1);
    chk("lm_err",  8'(sym), 8'd6);
    strobe(1'b1);
    chk("lm_v9",   8'(sym_valid), 8'd0);
    strobe(1'b1);
    chk("lm_v10",  8'(sym_valid), 8'd0);
    strobe(1'b0);
    chk("lm_rel_v", 8'(sym_valid), 8'd0);
    chk("lm_rel_b", 8'(busy), 8'd1);
    // space run started at 1: word gap needs six more spaces
    for (int i = 0; i < 5; i++) begin
      strobe(1'b0);
      chk("lm_sp_v", 8'(sym_valid), 8'd0);
    end
    strobe(1'b0);
    chk("lm_wg_v", 8'(sym_valid), 8'd1);
    chk("lm_wg_s", 8'(sym), 8'd4);
    chk("lm_wg_b", 8'(busy), 8'd0);

    // backpressure
    do_reset();
    sym_ready = 1'b0;
    strobe(1'b1);
    strobe(1'b0);
    chk("bp_dot_v", 8'(sym_valid), 8'd1);
    chk("bp_dot_s", 8'(sym), 8'd1);
    strobe(1'b1);
    strobe(1'b1);
    strobe(1'b1);
    chk("bp_hold_v", 8'(sym_valid), 8'd1);
    chk("bp_ovf0",   8'(overflow), 8'd0);
    strobe(1'b0);
    chk("bp_drop_s", 8'(sym), 8'd1);
    chk("bp_drop_v", 8'(sym_valid), 8'd1);
    chk("bp_ovf1",   8'(overflow), 8'd1);
    strobe(1'b0);
    strobe(1'b0);
    chk("bp_keep_s", 8'(sym), 8'd1);
    sym_ready = 1'b1;
    strobe(1'b1);
    chk("bp_lg_s",  8'(sym), 8'd2);
    chk("bp_lg_v",  8'(sym_valid), 8'd1);
    chk("bp_ovf2",  8'(overflow), 8'd1);
    idle_cycle();
    chk("bp_clr_v", 8'(sym_valid), 8'd0);
    chk("bp_clr_s", 8'(sym), 8'd2);

    // reset mid-mark (state is MARK, overflow still set)
    strobe(1'b1);
    strobe(1'b1);
    strobe(1'b1);
    chk("rm_busy_pre", 8'(busy), 8'd1);
    chk("rm_ovf_pre",  8'(overflow), 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_valid", 8'(sym_valid), 8'd0);
    chk("rm_busy",  8'(busy), 8'd0);
    chk("rm_ovf",   8'(overflow), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();
    strobe(1'b1);
    chk("rm_v1", 8'(sym_valid), 8'd0);
    strobe(1'b0);
    chk("rm_v2",  8'(sym_valid), 8'd1);
    chk("rm_dot", 8'(sym), 8'd1);
    idle_cycle();
    chk("rm_v3",  8'(sym_valid), 8'd0);
    chk("rm_ovf_end", 8'(overflow), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/morse_shift_in.md
# morse_shift_in

Serial-to-symbol Morse receiver. It is the counterpart of the transmit shifter and sits on the receive side of the keyed-line path. It samples a keyed serial line once per Morse unit, measures mark and space run lengths, and classifies them into element, gap and error symbols. Symbols are handed to the downstream decoder through a one-deep valid/ready output register.

## Interface
Parameters:
- CNT_W, 4: run-length counter width; counter saturates at 2^CNT_W-1.
- DASH_MIN, 3: minimum mark run (units) classified as DASH.
- LETTER_MIN, 3: minimum space run classified as LETTER_GAP.
- WORD_MIN, 7: space run that emits WORD_GAP.
- ERR_MARK, 8: mark run that emits ERR.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- S_DATA  in  1  keyed line; 1 = mark, 0 = space.
- sample  in  1  unit strobe, one-cycle pulse; S_DATA is acted on only when sample=1.
- sym  out  3  symbol code: DOT=3'd1, DASH=3'd7, LETTER_GAP=3'd2, WORD_GAP=3'd4, ERR=3'd6.
- sym_valid  out  1  sym holds an unconsumed symbol.
- sym_ready  in  1  consumer accepts sym this cycle when sym_valid=1.
- overflow  out  1  sticky flag; a symbol was dropped. Cleared only by reset.
- busy  out  1  high when state is not IDLE.

## Operation
- States: IDLE, MARK, SPACE. One run counter `cnt` (CNT_W bits).
- Reset state: IDLE, cnt=0, sym=3'd0, sym_valid=0, overflow=0, busy=0.
- All transitions below occur only on cycles with sample=1. With sample=0, state and cnt hold.
- IDLE:
  - S_DATA=0: stay in IDLE; spaces are not counted, so leading silence emits nothing.
  - S_DATA=1: go to MARK, cnt=1.
- MARK:
  - S_DATA=1: cnt increments, saturating. When the new cnt equals ERR_MARK, emit ERR once.
  - S_DATA=0: if cnt < ERR_MARK, emit DOT when cnt < DASH_MIN, else DASH. If cnt >= ERR_MARK, emit nothing. Go to SPACE, cnt=1.
- SPACE:
  - S_DATA=0: cnt increments. When the new cnt equals WORD_MIN, emit WORD_GAP and go to IDLE.
  - S_DATA=1: if LETTER_MIN <= cnt < WORD_MIN, emit LETTER_GAP. Spaces shorter than LETTER_MIN are element gaps and emit nothing. Go to MARK, cnt=1.
- At most one symbol is produced per sample.
- Output register:
  - An emit with sym_valid=0 loads sym and sets sym_valid.
  - An emit with sym_valid=1 and sym_ready=1 in the same cycle loads the new sym; sym_valid stays 1; no overflow.
  - An emit with sym_valid=1 and sym_ready=0 drops the new symbol, keeps the old one, and sets overflow.
  - sym_valid=1 and sym_ready=1 with no emit clears sym_valid; sym keeps its last value.
- Reset asserted mid-run returns to the reset state immediately. A partial run is discarded and a pending symbol is lost.

## Timing
- Emission latency: sym and sym_valid update on the clk edge that samples the triggering sample=1 cycle. They are visible the cycle after the strobe.
- busy follows state with the same one-edge timing.
- DOT/DASH appears on the strobe of the first space after the mark. LETTER_GAP appears on the strobe of the first mark after the gap.
- WORD_GAP appears on the WORD_MIN-th consecutive space strobe, without waiting for the next mark.
- ERR appears on the ERR_MARK-th consecutive mark strobe.
- sym_ready is sampled only when sym_valid=1. sym and sym_valid are stable while sym_valid=1 and sym_ready=0, except for the overflow-drop rule.
- Sample strobes in consecutive cycles are legal.

## Test plan
- Idle line: reset, then 20 strobes with S_DATA=0 -> no sym_valid, busy=0, overflow=0.
- Letter sequence: strobe S_DATA = 1,0,1,1,1,0,0,0,1,0 with sym_ready=1 -> symbols DOT, DASH, LETTER_GAP, DOT in that order. Each symbol is valid the cycle after strobes 2, 6, 9 and 10 respectively.
- Word gap: 1 then seven 0s -> DOT after strobe 2, WORD_GAP after strobe 8, busy=0 after strobe 8. Five further 0s -> nothing.
- Long mark: ten 1s then 0 -> ERR after the 8th mark strobe. Nothing is emitted on release. State is SPACE with cnt=1.
- Backpressure:
  - sym_ready=0; send 1,0,1,1,1,0 -> sym stays DOT, sym_valid=1, overflow=1.
  - Then assert sym_ready in the same cycle as a new emit -> new symbol loaded, sym_valid stays 1, overflow stays 1.
- Reset mid-mark: three mark strobes, then pulse rst_n low -> sym_valid=0, busy=0, overflow=0. A following 1,0 yields a single DOT.
